// File: rtl/instruction_fetch_queue_if.sv
// Fetch-unit bundle: ICache request/response, predictor query, jalr resolve,
// RoB flush and the Dispatcher-facing instruction queue head.
interface instruction_fetch_queue_if #(
  parameter int unsigned IQ_WIDTH = 2
);
  logic                icache_query_en;
  logic [31:0]         icache_query_pc;
  logic                icache_data_en;
  logic [31:0]         icache_addr_comfirm;
  logic [31:0]         icache_data;
  logic                branch_predictor_query_en;
  logic [31:0]         predict_query_pc;
  logic                predict_result;
  logic                jalr_result_en;
  logic [31:0]         jalr_result;
  logic                flush_signal;
  logic [31:0]         correct_next_pc;
  logic                new_instruction_able;
  logic                new_instruction_en;
  logic [31:0]         new_instruction;
  logic [31:0]         new_pc;
  logic                new_predict_result;
  logic [IQ_WIDTH:0]   iq_count;

  modport master (
    output icache_query_en, icache_query_pc, branch_predictor_query_en, predict_query_pc,
           new_instruction_en, new_instruction, new_pc, new_predict_result, iq_count,
    input  icache_data_en, icache_addr_comfirm, icache_data, predict_result,
           jalr_result_en, jalr_result, flush_signal, correct_next_pc, new_instruction_able
  );

  modport slave (
    input  icache_query_en, icache_query_pc, branch_predictor_query_en, predict_query_pc,
           new_instruction_en, new_instruction, new_pc, new_predict_result, iq_count,
    output icache_data_en, icache_addr_comfirm, icache_data, predict_result,
           jalr_result_en, jalr_result, flush_signal, correct_next_pc, new_instruction_able
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// RV32I fetch unit with a 2^IQ_WIDTH-entry instruction queue toward the Dispatcher.
// Define IFQ_BTFN_EN for static backward-taken/forward-not-taken branch prediction.
module instruction_fetch_queue #(
  parameter int unsigned IQ_WIDTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                       clk_in,
  input logic                       rst_n_in,
  input logic                       rdy_in,
  instruction_fetch_queue_if.master bus
);

  localparam int unsigned DEPTH = 1 << IQ_WIDTH;
  localparam int unsigned CW    = IQ_WIDTH + 1;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic {FETCH, WAIT_JALR} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [IQ_WIDTH-1:0]   head_q, head_d;
  logic [IQ_WIDTH-1:0]   tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  drop_q, drop_d;
  logic                  qen_q, qen_d;
  logic [31:0]           qpc_q, qpc_d;
  entry_t                mem_q [DEPTH];

  logic                  enq;
  logic                  deq;
  entry_t                enq_entry;
  logic                  accept;

  logic [6:0]            opcode;
  logic [31:0]           j_imm;
  logic [31:0]           b_imm;
  logic                  is_branch;
  logic                  is_jalr;
  logic                  br_taken;
  logic                  stored_pred;
  logic [31:0]           next_pc;

  // Decode of the arriving word: immediates, prediction and successor PC
  always_comb begin
    opcode    = bus.icache_data[6:0];
    j_imm     = {{12{bus.icache_data[31]}}, bus.icache_data[19:12], bus.icache_data[20],
                 bus.icache_data[30:21], 1'b0};
    b_imm     = {{20{bus.icache_data[31]}}, bus.icache_data[7], bus.icache_data[30:25],
                 bus.icache_data[11:8], 1'b0};
    is_branch = (opcode == OP_BRANCH);
    is_jalr   = (opcode == OP_JALR);
`ifdef IFQ_BTFN_EN
    br_taken  = b_imm[31];
`else
    br_taken  = bus.predict_result;
`endif
    stored_pred = is_branch && br_taken;
    next_pc     = qpc_q + 32'd4;
    if (opcode == OP_JAL) begin
      next_pc = qpc_q + j_imm;
    end else if (is_branch && br_taken) begin
      next_pc = qpc_q + b_imm;
    end
  end

  assign accept = qen_q && bus.icache_data_en && !drop_q &&
                  (bus.icache_addr_comfirm == qpc_q);

  // Next-state and queue-pointer logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    drop_d    = drop_q;
    qen_d     = qen_q;
    qpc_d     = qpc_q;
    enq       = 1'b0;
    deq       = 1'b0;
    enq_entry = '0;

    if (rdy_in) begin
      if (bus.flush_signal) begin
        // An outstanding request whose response is not here yet must be swallowed later
        state_d = FETCH;
        pc_d    = bus.correct_next_pc;
        qpc_d   = bus.correct_next_pc;
        qen_d   = 1'b0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        drop_d  = (drop_q || qen_q) && !bus.icache_data_en;
      end else begin
        deq = (count_q != '0) && bus.new_instruction_able;
        enq = accept;
        if (bus.icache_data_en) begin
          drop_d = 1'b0;
        end
        if (enq) begin
          enq_entry = '{instr: bus.icache_data, pc: qpc_q, pred: stored_pred};
          tail_d    = tail_q + IQ_WIDTH'(1);
        end
        if (deq) begin
          head_d = head_q + IQ_WIDTH'(1);
        end
        count_d = count_q + CW'(enq) - CW'(deq);

        unique case (state_q)
          FETCH: begin
            if (accept) begin
              pc_d  = next_pc;
              qpc_d = next_pc;
              if (is_jalr) begin
                state_d = WAIT_JALR;
                qen_d   = 1'b0;
              end else begin
                qen_d = (count_d < CW'(DEPTH));
              end
            end else if (!qen_q && !drop_q && (count_q < CW'(DEPTH))) begin
              qen_d = 1'b1;
              qpc_d = pc_q;
            end
          end
          WAIT_JALR: begin
            if (bus.jalr_result_en) begin
              pc_d    = bus.jalr_result & ~32'd1;
              state_d = FETCH;
            end
          end
          default: state_d = FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
      qen_q   <= 1'b0;
      qpc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      qen_q   <= qen_d;
      qpc_q   <= qpc_d;
    end
  end

  // Queue storage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq) begin
      mem_q[tail_q] <= enq_entry;
    end
  end

  assign bus.icache_query_en    = qen_q;
  assign bus.icache_query_pc    = qpc_q;
  assign bus.predict_query_pc   = qpc_q;
  assign bus.iq_count           = count_q;
  assign bus.new_instruction_en = (count_q != '0);
  assign bus.new_instruction    = bus.new_instruction_en ? mem_q[head_q].instr : 32'd0;
  assign bus.new_pc             = bus.new_instruction_en ? mem_q[head_q].pc : 32'd0;
  assign bus.new_predict_result = bus.new_instruction_en && mem_q[head_q].pred;

`ifdef IFQ_BTFN_EN
  logic unused_predict;
  assign unused_predict                = bus.predict_result;
  assign bus.branch_predictor_query_en = 1'b0;
`else
  assign bus.branch_predictor_query_en = qen_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: vector table for fill/backpressure/freeze,
// hand sequences for jal/branch redirect, jalr stall and flush with a stale response.
module tb_instruction_fetch_queue;

  localparam int unsigned IQW = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] JAL40   = 32'h0400_006F;
  localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
  localparam logic [31:0] BNE_P20 = 32'h0200_1063;
  localparam logic [31:0] JALR    = 32'h0000_8067;
`ifdef IFQ_BTFN_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  always #5 clk = ~clk;

  instruction_fetch_queue_if #(.IQ_WIDTH(IQW)) bus ();

  instruction_fetch_queue #(.IQ_WIDTH(IQW), .RESET_PC(32'h0)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int prog_sel;
  logic        hold_en;
  logic [31:0] hold_pc;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  logic        pop_pred[$];

  typedef struct {
    logic        rdy;
    logic        able;
    logic        en;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        qen;
    logic [31:0] qpc;
  } vec_t;
  vec_t vt[16];

  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] w;
    w = NOP;
    if (prog_sel == 2) begin
      if (a == 32'h08) w = JAL40;
      if (a == 32'h48) w = BEQ_M8;
      if (a == 32'h40) w = BNE_P20;
    end
    if (prog_sel == 3 && a == 32'h20) w = JALR;
    return w;
  endfunction

  // Dynamic predictor answers chosen so both builds walk the same path
  function automatic logic pred_of(input logic [31:0] a);
    return BTFN ? (a == 32'h40) : (a == 32'h48);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Record the pop consumed by the coming edge, pass the edge, then answer as a 1-cycle ICache
  task automatic step();
    if (rdy && rst_n && bus.new_instruction_en && bus.new_instruction_able && !bus.flush_signal) begin
      pop_pc.push_back(bus.new_pc);
      pop_ins.push_back(bus.new_instruction);
      pop_pred.push_back(bus.new_predict_result);
    end
    @(negedge clk);
    if (bus.icache_query_en && !(hold_en && bus.icache_query_pc == hold_pc)) begin
      bus.icache_data_en      = 1'b1;
      bus.icache_addr_comfirm = bus.icache_query_pc;
      bus.icache_data         = imem(bus.icache_query_pc);
      bus.predict_result      = pred_of(bus.icache_query_pc);
    end else begin
      bus.icache_data_en      = 1'b0;
      bus.icache_addr_comfirm = 32'h0;
      bus.icache_data         = 32'h0;
      bus.predict_result      = 1'b0;
    end
  endtask

  task automatic do_reset(input int sel);
    rst_n                    = 1'b0;
    rdy                      = 1'b1;
    prog_sel                 = sel;
    hold_en                  = 1'b0;
    hold_pc                  = 32'h0;
    bus.icache_data_en       = 1'b0;
    bus.icache_addr_comfirm  = 32'h0;
    bus.icache_data          = 32'h0;
    bus.predict_result       = 1'b0;
    bus.jalr_result_en       = 1'b0;
    bus.jalr_result          = 32'h0;
    bus.flush_signal         = 1'b0;
    bus.correct_next_pc      = 32'h0;
    bus.new_instruction_able = 1'b0;
    pop_pc.delete();
    pop_ins.delete();
    pop_pred.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc[8];
    logic [31:0] exp_ins[8];
    logic        exp_pred[8];
    int          c;

    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 3'd0, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 32'h00, 3'd0, 1'b1, 32'h00};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd1, 1'b1, 32'h04};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd2, 1'b1, 32'h08};
    vt[4]  = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd3, 1'b1, 32'h0C};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 32'h00, 3'd4, 1'b0, 32'h00};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h00, 3'd4, 1'b0, 32'h00};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h04, 3'd3, 1'b0, 32'h00};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 32'h08, 3'd2, 1'b1, 32'h10};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 3'd2, 1'b1, 32'h14};
    vt[10] = '{1'b1, 1'b1, 1'b1, 32'h10, 3'd2, 1'b1, 32'h18};
    vt[11] = '{1'b1, 1'b1, 1'b1, 32'h14, 3'd2, 1'b1, 32'h1C};
    vt[12] = '{1'b1, 1'b1, 1'b1, 32'h18, 3'd2, 1'b1, 32'h20};
    vt[13] = '{1'b0, 1'b1, 1'b1, 32'h1C, 3'd2, 1'b1, 32'h24};
    vt[14] = '{1'b1, 1'b1, 1'b1, 32'h1C, 3'd2, 1'b1, 32'h24};
    vt[15] = '{1'b1, 1'b1, 1'b1, 32'h20, 3'd2, 1'b1, 32'h28};

    // Reset values
    do_reset(1);
    chk("rst_qen",   32'(bus.icache_query_en), 32'd0);
    chk("rst_qpc",   bus.icache_query_pc, 32'h0);
    chk("rst_bpen",  32'(bus.branch_predictor_query_en), 32'd0);
    chk("rst_bppc",  bus.predict_query_pc, 32'h0);
    chk("rst_en",    32'(bus.new_instruction_en), 32'd0);
    chk("rst_instr", bus.new_instruction, 32'h0);
    chk("rst_pc",    bus.new_pc, 32'h0);
    chk("rst_pred",  32'(bus.new_predict_result), 32'd0);
    chk("rst_cnt",   32'(bus.iq_count), 32'd0);

    // Fill to full under backpressure, resume, sustained throughput, rdy freeze
    for (int v = 0; v < 16; v++) begin
      chk($sformatf("v%0d_en", v), 32'(bus.new_instruction_en), 32'(vt[v].en));
      if (vt[v].en) begin
        chk($sformatf("v%0d_pc", v), bus.new_pc, vt[v].pc);
        chk($sformatf("v%0d_instr", v), bus.new_instruction, NOP);
        chk($sformatf("v%0d_pred", v), 32'(bus.new_predict_result), 32'd0);
      end
      chk($sformatf("v%0d_cnt", v), 32'(bus.iq_count), 32'(vt[v].cnt));
      chk($sformatf("v%0d_qen", v), 32'(bus.icache_query_en), 32'(vt[v].qen));
      chk($sformatf("v%0d_bpen", v), 32'(bus.branch_predictor_query_en),
          32'(vt[v].qen && !BTFN));
      if (vt[v].qen) begin
        chk($sformatf("v%0d_qpc", v), bus.icache_query_pc, vt[v].qpc);
        chk($sformatf("v%0d_bppc", v), bus.predict_query_pc, vt[v].qpc);
      end
      rdy                      = vt[v].rdy;
      bus.new_instruction_able = vt[v].able;
      step();
    end

    // jal and predicted branches
    exp_pc   = '{32'h00, 32'h04, 32'h08, 32'h48, 32'h40, 32'h44, 32'h48, 32'h40};
    exp_ins  = '{NOP, NOP, JAL40, BEQ_M8, BNE_P20, NOP, BEQ_M8, BNE_P20};
    exp_pred = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset(2);
    bus.new_instruction_able = 1'b1;
    c = 0;
    while (c < 40 && pop_pc.size() < 8) begin
      step();
      c++;
    end
    chk("br_pops", 32'(pop_pc.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_pc.size()) begin
        chk($sformatf("br%0d_pc", i), pop_pc[i], exp_pc[i]);
        chk($sformatf("br%0d_instr", i), pop_ins[i], exp_ins[i]);
        chk($sformatf("br%0d_pred", i), 32'(pop_pred[i]), 32'(exp_pred[i]));
      end
    end

    // jalr stall; a jalr result seen while fetching must be ignored
    do_reset(3);
    bus.new_instruction_able = 1'b1;
    bus.jalr_result_en       = 1'b1;
    bus.jalr_result          = 32'h500;
    step();
    bus.jalr_result_en = 1'b0;
    repeat (20) step();
    chk("jalr_stall_qen", 32'(bus.icache_query_en), 32'd0);
    chk("jalr_pops", 32'(pop_pc.size()), 32'd9);
    if (pop_pc.size() == 9) begin
      chk("jalr_last_pc", pop_pc[8], 32'h20);
      chk("jalr_last_instr", pop_ins[8], JALR);
    end
    bus.jalr_result_en = 1'b1;
    bus.jalr_result    = 32'h101;
    step();
    bus.jalr_result_en = 1'b0;
    chk("jalr_resume_qen0", 32'(bus.icache_query_en), 32'd0);
    step();
    chk("jalr_resume_qen1", 32'(bus.icache_query_en), 32'd1);
    chk("jalr_resume_qpc", bus.icache_query_pc, 32'h100);
    repeat (4) step();
    chk("jalr_tgt_pops", 32'(pop_pc.size() >= 11), 32'd1);
    if (pop_pc.size() >= 11) begin
      chk("jalr_tgt_pc0", pop_pc[9], 32'h100);
      chk("jalr_tgt_pc1", pop_pc[10], 32'h104);
    end

    // Flush with the 0x30 request outstanding; its late response must be dropped
    do_reset(1);
    bus.new_instruction_able = 1'b1;
    hold_en = 1'b1;
    hold_pc = 32'h30;
    c = 0;
    while (c < 40 && !(bus.icache_query_en && bus.icache_query_pc == 32'h30)) begin
      step();
      c++;
    end
    chk("fl_reach_30", 32'(bus.icache_query_en && bus.icache_query_pc == 32'h30), 32'd1);
    bus.flush_signal    = 1'b1;
    bus.correct_next_pc = 32'h200;
    step();
    bus.flush_signal = 1'b0;
    chk("fl_en",  32'(bus.new_instruction_en), 32'd0);
    chk("fl_cnt", 32'(bus.iq_count), 32'd0);
    chk("fl_qen", 32'(bus.icache_query_en), 32'd0);
    step();
    chk("fl_drop_blocks_qen", 32'(bus.icache_query_en), 32'd0);
    bus.icache_data_en      = 1'b1;
    bus.icache_addr_comfirm = 32'h30;
    bus.icache_data         = NOP;
    step();
    chk("fl_stale_cnt", 32'(bus.iq_count), 32'd0);
    chk("fl_stale_qen", 32'(bus.icache_query_en), 32'd0);
    step();
    chk("fl_new_qen", 32'(bus.icache_query_en), 32'd1);
    chk("fl_new_qpc", bus.icache_query_pc, 32'h200);
    bus.icache_addr_comfirm = 32'h204;
    step();
    chk("mis_cnt", 32'(bus.iq_count), 32'd0);
    chk("mis_qen", 32'(bus.icache_query_en), 32'd1);
    chk("mis_qpc", bus.icache_query_pc, 32'h200);
    step();
    chk("fl_first_en",  32'(bus.new_instruction_en), 32'd1);
    chk("fl_first_pc",  bus.new_pc, 32'h200);
    chk("fl_first_cnt", 32'(bus.iq_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
